// File: rtl/short_preamble_gen_if.sv
// ---------------------------------------------------------------------------
// short_preamble_gen_if
// Control and sample-stream bundle for the STF generator.
//   start             : single-cycle sequence request
//   num_periods       : number of 16-sample STF periods to emit
//   gain_shift        : left shift applied to the STF table values (0..3)
//   sample_out_ready  : downstream request, one sample per high cycle
//   sample_out        : {I[31:16], Q[15:0]} two's complement sample
//   sample_out_strobe : one-cycle valid for sample_out
//   sample_index      : 0-based index of the sample on sample_out
//   busy              : sequence in progress
//   done              : one-cycle end-of-sequence pulse
// master = the controller/consumer side, slave = the generator.
// ---------------------------------------------------------------------------
interface short_preamble_gen_if;
    logic        start;
    logic [3:0]  num_periods;
    logic [1:0]  gain_shift;
    logic        sample_out_ready;
    logic [31:0] sample_out;
    logic        sample_out_strobe;
    logic [7:0]  sample_index;
    logic        busy;
    logic        done;

    modport master (
        output start, num_periods, gain_shift, sample_out_ready,
        input  sample_out, sample_out_strobe, sample_index, busy, done
    );

    modport slave (
        input  start, num_periods, gain_shift, sample_out_ready,
        output sample_out, sample_out_strobe, sample_index, busy, done
    );
endinterface

// File: rtl/short_preamble_gen.sv
// ---------------------------------------------------------------------------
// short_preamble_gen
// Transmit-side generator for the 802.11a/g short training field. On an
// accepted start it streams num_periods x 16 STF samples, scaled by
// gain_shift, one per cycle in which the downstream raises ready. With
// WINDOW_EN set, the first sample is halved and a halved copy of table
// entry 0 is appended as a tail sample.
// Ports:
//   clock  : system clock
//   reset  : asynchronous active-low reset
//   enable : when low, all state freezes and strobe/done are forced low
//   sp     : control / sample stream bundle (slave side)
// ---------------------------------------------------------------------------
module short_preamble_gen #(
    parameter bit WINDOW_EN = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    short_preamble_gen_if.slave  sp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TAIL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [7:0]         count_r;
    logic [7:0]         count_next_s;
    logic [7:0]         total_r;
    logic [1:0]         gain_r;
    logic               accept_s;
    logic               emit_s;
    logic               halve_s;
    logic [31:0]        rom_iq_s;
    logic signed [15:0] rom_i_s;
    logic signed [15:0] rom_q_s;
    logic signed [15:0] scaled_i_s;
    logic signed [15:0] scaled_q_s;
    logic signed [15:0] out_i_s;
    logic signed [15:0] out_q_s;

    logic [31:0]        sample_out_r;
    logic               sample_out_strobe_r;
    logic [7:0]         sample_index_r;
    logic               busy_r;
    logic               done_r;

    // One STF period, {I, Q}, unscaled.
    function automatic logic [31:0] stf_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    stf_rom = {16'sd377,   16'sd377};
            4'd1:    stf_rom = {-16'sd1085, 16'sd19};
            4'd2:    stf_rom = {-16'sd111,  -16'sd643};
            4'd3:    stf_rom = {16'sd1170,  -16'sd111};
            4'd4:    stf_rom = {16'sd754,   16'sd0};
            4'd5:    stf_rom = {16'sd1170,  -16'sd111};
            4'd6:    stf_rom = {-16'sd111,  -16'sd643};
            4'd7:    stf_rom = {-16'sd1085, 16'sd19};
            4'd8:    stf_rom = {16'sd377,   16'sd377};
            4'd9:    stf_rom = {16'sd19,    -16'sd1085};
            4'd10:   stf_rom = {-16'sd643,  -16'sd111};
            4'd11:   stf_rom = {-16'sd111,  16'sd1170};
            4'd12:   stf_rom = {16'sd0,     16'sd754};
            4'd13:   stf_rom = {-16'sd111,  16'sd1170};
            4'd14:   stf_rom = {-16'sd643,  -16'sd111};
            4'd15:   stf_rom = {16'sd19,    -16'sd1085};
            default: stf_rom = 32'd0;
        endcase
    endfunction

    // Next-state and sample-counter logic.
    // count_r is the index of the next sample to emit. Once it reaches the
    // end of the stream the FSM spends one more enabled cycle before DONE so
    // that done lands one cycle after the last strobe. The tail sample index
    // is a multiple of 16, so count_r[3:0] selects table entry 0 for it.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        accept_s     = 1'b0;
        emit_s       = 1'b0;
        if (enable) begin
            case (state_r)
                ST_IDLE: begin
                    if (sp.start) begin
                        accept_s     = 1'b1;
                        count_next_s = 8'd0;
                        if (sp.num_periods == 4'd0) begin
                            state_next_s = ST_DONE;
                        end else begin
                            state_next_s = ST_RUN;
                        end
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (count_r == total_r) begin
                        state_next_s = ST_DONE;
                    end else if (sp.sample_out_ready) begin
                        emit_s       = 1'b1;
                        count_next_s = count_r + 8'd1;
                        if (WINDOW_EN && (count_r == (total_r - 8'd1))) begin
                            state_next_s = ST_TAIL;
                        end else begin
                            state_next_s = ST_RUN;
                        end
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_TAIL: begin
                    if (count_r == (total_r + 8'd1)) begin
                        state_next_s = ST_DONE;
                    end else if (sp.sample_out_ready) begin
                        emit_s       = 1'b1;
                        count_next_s = count_r + 8'd1;
                    end else begin
                        state_next_s = ST_TAIL;
                    end
                end
                ST_DONE: begin
                    state_next_s = ST_IDLE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Sample datapath: table lookup, gain shift, then optional halving.
    always_comb begin
        rom_iq_s   = stf_rom(count_r[3:0]);
        rom_i_s    = signed'(rom_iq_s[31:16]);
        rom_q_s    = signed'(rom_iq_s[15:0]);
        scaled_i_s = rom_i_s <<< gain_r;
        scaled_q_s = rom_q_s <<< gain_r;
        halve_s    = WINDOW_EN &&
                     (((state_r == ST_RUN) && (count_r == 8'd0)) ||
                      (state_r == ST_TAIL));
        if (halve_s) begin
            out_i_s = scaled_i_s >>> 1;
            out_q_s = scaled_q_s >>> 1;
        end else begin
            out_i_s = scaled_i_s;
            out_q_s = scaled_q_s;
        end
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r             <= ST_IDLE;
            count_r             <= 8'd0;
            total_r             <= 8'd0;
            gain_r              <= 2'd0;
            sample_out_r        <= 32'd0;
            sample_out_strobe_r <= 1'b0;
            sample_index_r      <= 8'd0;
            busy_r              <= 1'b0;
            done_r              <= 1'b0;
        end else begin
            state_r             <= state_next_s;
            count_r             <= count_next_s;
            sample_out_strobe_r <= emit_s;
            busy_r              <= (state_next_s != ST_IDLE);
            // Pulse only on entry so a DONE frozen by enable cannot repeat.
            done_r              <= (state_next_s == ST_DONE) && (state_r != ST_DONE);
            if (accept_s) begin
                total_r <= {sp.num_periods, 4'b0000};
                gain_r  <= sp.gain_shift;
            end else begin
                total_r <= total_r;
                gain_r  <= gain_r;
            end
            if (emit_s) begin
                sample_out_r   <= {out_i_s, out_q_s};
                sample_index_r <= count_r;
            end else begin
                sample_out_r   <= sample_out_r;
                sample_index_r <= sample_index_r;
            end
        end
    end

    assign sp.sample_out        = sample_out_r;
    assign sp.sample_out_strobe = sample_out_strobe_r;
    assign sp.sample_index      = sample_index_r;
    assign sp.busy              = busy_r;
    assign sp.done              = done_r;

endmodule
